// File: rtl/blur_anchor_sequencer_if.sv
// Blur anchor sequencer bus: start/busy/done control, pixel read
// port, blur controller anchor handshake and output write port.
// master = sequencer (initiator), slave = memory/blur environment.
interface blur_anchor_sequencer_if #(
  parameter int ADDR_W = 20
);
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   rd_req;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_valid;
  logic [7:0]             rd_data;
  logic                   anchor_moving;
  logic [31:0]            anchor_x;
  logic [31:0]            anchor_y;
  logic [19:0][7:0]       blur_in;
  logic                   blur_final;
  logic [15:0][7:0]       blur_out;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [127:0]           wr_data;

  modport master (
    input  start, rd_valid, rd_data,
    input  blur_final, blur_out, wr_ready,
    output busy, done, rd_req, rd_addr,
    output anchor_moving, anchor_x, anchor_y,
    output blur_in, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output start, rd_valid, rd_data,
    output blur_final, blur_out, wr_ready,
    input  busy, done, rd_req, rd_addr,
    input  anchor_moving, anchor_x, anchor_y,
    input  blur_in, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/blur_anchor_sequencer.sv
// Blur anchor sequencer: walks 16-px strips top-down, fetches
// 20-px clamped row segments, launches the blur controller and
// writes the 16 filtered pixels back.
// Ports: clk, n_rst (async active-low), bus (master modport).
// Optional: BLUR_PREFETCH_EN adds a second segment buffer and
// fetches the next anchor while the current one is in flight.
module blur_anchor_sequencer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_W     = 20
) (
  input  logic clk,
  input  logic n_rst,
  blur_anchor_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LAUNCH, WAIT, CAPTURE, WRITE
  } state_e;

  localparam logic [31:0] LAST_X = 32'(IMG_HEIGHT - 1);
  localparam logic [31:0] LAST_Y = 32'(IMG_WIDTH - 16);
  localparam logic [31:0] W32    = 32'(IMG_WIDTH);
  localparam logic [4:0]  SEG_N  = 5'd20;

  state_e state_q, state_d;

  logic [31:0]       ax_q, ay_q;
  logic [4:0]        iss_q, rsp_q;
  logic              busy_q, done_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [127:0]      wr_data_q;

  logic        last, wr_acc, start_ok;
  logic        pf_act, fetch_act, rd_go;
  logic        rsp_en, fetch_done;
  logic [31:0] nx, ny, fx, fy;
  logic [31:0] col_raw, col;

`ifdef BLUR_PREFETCH_EN
  logic [1:0][19:0][7:0] seg_q;
  logic                  sel_q;
`else
  logic [19:0][7:0]      seg_q;
`endif

  assign last = (ax_q == LAST_X) && (ay_q == LAST_Y);
  assign nx   = (ax_q == LAST_X) ? '0 : ax_q + 32'd1;
  assign ny   = (ax_q == LAST_X) ? ay_q + 32'd16 : ay_q;

  assign wr_acc   = (state_q == WRITE) && bus.wr_ready;
  assign start_ok = (state_q == IDLE) && bus.start && !done_q;

  // Prefetch targets the next anchor while this one is in flight.
`ifdef BLUR_PREFETCH_EN
  assign pf_act = !last && ((state_q == WAIT) ||
                            (state_q == CAPTURE) ||
                            (state_q == WRITE));
`else
  assign pf_act = 1'b0;
`endif

  assign fetch_act = (state_q == FETCH) || pf_act;
  assign rd_go     = fetch_act && (iss_q != SEG_N);

  // Responses only count while a request is still unanswered.
  assign rsp_en     = bus.rd_valid && (rsp_q < iss_q);
  assign fetch_done = (rsp_q == SEG_N) ||
                      (rsp_en && (rsp_q == SEG_N - 5'd1));

  assign fx      = pf_act ? nx : ax_q;
  assign fy      = pf_act ? ny : ay_q;
  assign col_raw = fy + {27'd0, iss_q};

  // Column fy-2+i, replicated at both image edges.
  always_comb begin
    col = col_raw - 32'd2;
    if (col_raw < 32'd2) begin
      col = '0;
    end else if (col_raw - 32'd2 > W32 - 32'd1) begin
      col = W32 - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: begin
        if (fetch_done) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.blur_final) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (bus.wr_ready) begin
          if (last) begin
            state_d = IDLE;
          end else if (pf_act && fetch_done) begin
            state_d = LAUNCH;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ax_q       <= '0;
      ay_q       <= '0;
      iss_q      <= '0;
      rsp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      seg_q      <= '0;
`ifdef BLUR_PREFETCH_EN
      sel_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (done_q) busy_q <= 1'b0;

      if (start_ok) begin
        busy_q <= 1'b1;
        ax_q   <= '0;
        ay_q   <= '0;
        iss_q  <= '0;
        rsp_q  <= '0;
      end else if (state_q == LAUNCH) begin
        iss_q <= '0;
        rsp_q <= '0;
      end else begin
        if (rd_go)  iss_q <= iss_q + 5'd1;
        if (rsp_en) rsp_q <= rsp_q + 5'd1;
      end

      if (rsp_en) begin
`ifdef BLUR_PREFETCH_EN
        seg_q[pf_act ? ~sel_q : sel_q][rsp_q] <= bus.rd_data;
`else
        seg_q[rsp_q] <= bus.rd_data;
`endif
      end

      if (state_q == CAPTURE) begin
        wr_valid_q <= 1'b1;
        wr_addr_q  <= ADDR_W'(ax_q * W32 + ay_q);
        wr_data_q  <= bus.blur_out;
      end

      if (wr_acc) begin
        wr_valid_q <= 1'b0;
        if (last) begin
          done_q <= 1'b1;
          ax_q   <= '0;
          ay_q   <= '0;
        end else begin
          ax_q <= nx;
          ay_q <= ny;
`ifdef BLUR_PREFETCH_EN
          sel_q <= ~sel_q;
`endif
        end
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rd_req        = rd_go;
  assign bus.rd_addr       = rd_go ? ADDR_W'(fx * W32 + col) : '0;
  assign bus.anchor_moving = (state_q == LAUNCH);
  assign bus.anchor_x      = ax_q;
  assign bus.anchor_y      = ay_q;
  assign bus.wr_valid      = wr_valid_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;

`ifdef BLUR_PREFETCH_EN
  assign bus.blur_in = seg_q[sel_q];
`else
  assign bus.blur_in = seg_q;
`endif

endmodule
